// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the Newton-Raphson datapath adders.
// Holds field widths, the adder FSM state type and significand helpers.
package fp_pkg;
   localparam int FP_W    = 32;
   localparam int EXP_W   = 8;
   localparam int MAN_W   = 23;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = 2 * BIAS + 1;
   // Hidden bit, mantissa, then guard/round/sticky.
   localparam int FRAME_W = MAN_W + 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_ADD,
      ST_NORM,
      ST_ROUND,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp32_t;

   // Subnormals behave as exponent 1 with no hidden bit.
   function automatic logic [EXP_W-1:0] eff_exp(input fp32_t x);
      return (x.exp == '0) ? EXP_W'(1) : x.exp;
   endfunction

   function automatic logic [FRAME_W-1:0] to_frame(input fp32_t x);
      return {x.exp != '0, x.man, 3'b000};
   endfunction
endpackage

// File: rtl/fp_addsub_seq_if.sv
// Operand/result handshake bundle between a producer, the sequential adder
// and the consumer of its sums.
interface fp_addsub_seq_if;
   import fp_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [FP_W-1:0] a_operand;
   logic [FP_W-1:0] b_operand;
   logic            sub;
   logic            out_valid;
   logic            out_ready;
   logic [FP_W-1:0] result;
   logic            Exception;
   logic            Overflow;
   logic            Underflow;

   modport master (
      output in_valid, a_operand, b_operand, sub, out_ready,
      input  in_ready, out_valid, result, Exception, Overflow, Underflow
   );

   modport slave (
      input  in_valid, a_operand, b_operand, sub, out_ready,
      output in_ready, out_valid, result, Exception, Overflow, Underflow
   );
endinterface

// File: rtl/fp_align_shifter.sv
// Right barrel shift of a significand frame; every bit shifted out is
// folded into the sticky LSB so rounding still sees it.
module fp_align_shifter
   import fp_pkg::*;
(
   input  logic [FRAME_W-1:0] frame_i,
   input  logic [EXP_W-1:0]   shamt_i,
   output logic [FRAME_W-1:0] frame_o
);
   logic [FRAME_W-1:0] shifted;
   logic [FRAME_W-1:0] lost;

   assign shifted = frame_i >> shamt_i;

   generate
      for (genvar gi = 0; gi < FRAME_W; gi++) begin : g_lost
         assign lost[gi] = frame_i[gi] & (EXP_W'(gi) < shamt_i);
      end
   endgenerate

   assign frame_o = {shifted[FRAME_W-1:1], shifted[0] | (|lost)};
endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle FP32 adder/subtractor: align, add, normalise one bit per
// cycle, round to nearest even, then hold the result until accepted.
module fp_addsub_seq
   import fp_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   fp_addsub_seq_if.slave bus
);
   state_e             state_q, state_d;
   fp32_t              a_q, a_d, b_q, b_d;
   logic               sub_q, sub_d, sign_q, sign_d, eff_sub_q, eff_sub_d;
   logic [9:0]         exp_q, exp_d;
   logic [FRAME_W-1:0] big_q, big_d, small_q, small_d;
   logic [FRAME_W:0]   mant_q, mant_d;
   logic [FP_W-1:0]    result_q, result_d;
   logic               exc_q, exc_d, ovf_q, ovf_d, unf_q, unf_d;

   fp32_t              in_a, in_b, b_signed, big_op, small_op;
   logic               a_ge_b;
   logic [EXP_W-1:0]   shamt;
   logic [FRAME_W-1:0] small_frame, small_aligned;
   logic [FRAME_W:0]   sum;
   logic [24:0]        rnd_sum;
   logic [23:0]        rnd_sig;
   logic [9:0]         rnd_exp;

   assign in_a = bus.a_operand;
   assign in_b = bus.b_operand;

   // Magnitude order: exponent field first, then mantissa.
   always_comb begin
      b_signed      = b_q;
      b_signed.sign = b_q.sign ^ sub_q;
      a_ge_b        = {a_q.exp, a_q.man} >= {b_q.exp, b_q.man};
      big_op        = a_ge_b ? a_q : b_signed;
      small_op      = a_ge_b ? b_signed : a_q;
      shamt         = eff_exp(big_op) - eff_exp(small_op);
   end

   assign small_frame = to_frame(small_op);

   fp_align_shifter u_align (
      .frame_i (small_frame),
      .shamt_i (shamt),
      .frame_o (small_aligned)
   );

   assign sum = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                          : ({1'b0, big_q} + {1'b0, small_q});

   always_comb begin
      rnd_sum = {1'b0, mant_q[26:3]} + 25'(mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]));
      rnd_sig = rnd_sum[23:0];
      rnd_exp = exp_q;
      if (rnd_sum[24]) begin
         rnd_sig = rnd_sum[24:1];
         rnd_exp = exp_q + 10'd1;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sub_d     = sub_q;
      sign_d    = sign_q;
      eff_sub_d = eff_sub_q;
      exp_d     = exp_q;
      big_d     = big_q;
      small_d   = small_q;
      mant_d    = mant_q;
      result_d  = result_q;
      exc_d     = exc_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               exc_d = 1'b0;
               ovf_d = 1'b0;
               unf_d = 1'b0;
               if (in_a.exp == EXP_W'(EXP_MAX) || in_b.exp == EXP_W'(EXP_MAX)) begin
                  exc_d    = 1'b1;
                  result_d = '0;
                  state_d  = ST_DONE;
               end else begin
                  a_d     = in_a;
                  b_d     = in_b;
                  sub_d   = bus.sub;
                  state_d = ST_ALIGN;
               end
            end
         end
         ST_ALIGN: begin
            sign_d    = big_op.sign;
            eff_sub_d = big_op.sign ^ small_op.sign;
            exp_d     = 10'(eff_exp(big_op));
            big_d     = to_frame(big_op);
            small_d   = small_aligned;
            state_d   = ST_ADD;
         end
         ST_ADD: begin
            mant_d = sum;
            if (sum == '0) begin
               result_d = '0;
               state_d  = ST_DONE;
            end else begin
               state_d = ST_NORM;
            end
         end
         ST_NORM: begin
            if (mant_q[27]) begin
               mant_d  = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
               exp_d   = exp_q + 10'd1;
               state_d = ST_ROUND;
            end else if (mant_q[26] || exp_q == 10'd1) begin
               state_d = ST_ROUND;
            end else begin
               mant_d = {mant_q[26:0], 1'b0};
               exp_d  = exp_q - 10'd1;
            end
         end
         ST_ROUND: begin
            if (rnd_exp >= 10'(EXP_MAX)) begin
               result_d = {sign_q, EXP_W'(EXP_MAX), MAN_W'(0)};
               ovf_d    = 1'b1;
            end else if (!rnd_sig[23]) begin
               result_d = {sign_q, EXP_W'(0), rnd_sig[22:0]};
               unf_d    = |rnd_sig[22:0];
            end else begin
               result_d = {sign_q, rnd_exp[7:0], rnd_sig[22:0]};
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sub_q     <= 1'b0;
         sign_q    <= 1'b0;
         eff_sub_q <= 1'b0;
         exp_q     <= '0;
         big_q     <= '0;
         small_q   <= '0;
         mant_q    <= '0;
         result_q  <= '0;
         exc_q     <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sub_q     <= sub_d;
         sign_q    <= sign_d;
         eff_sub_q <= eff_sub_d;
         exp_q     <= exp_d;
         big_q     <= big_d;
         small_q   <= small_d;
         mant_q    <= mant_d;
         result_q  <= result_d;
         exc_q     <= exc_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.result    = result_q;
   assign bus.Exception = exc_q;
   assign bus.Overflow  = ovf_q;
   assign bus.Underflow = unf_q;
endmodule
